// File: rtl/buf_req_arbiter.sv
// rtl/buf_req_arbiter.sv - round-robin arbiter sharing one BUF sender port among N four-phase requesters
// Define ARB_TIMEOUT_EN to abort a grant when out_ack never arrives within TIMEOUT cycles.
module buf_req_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 32,
  parameter int IW      = $clog2(N),
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data_in,
  output logic [N-1:0]       ack,
  output logic               out_req,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ack,
  output logic               busy,
  output logic [IW-1:0]      grant_idx,
  output logic               err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, ACKD, DROP} state_t;

  state_t        state;
  logic [IW-1:0] lastPtr;
  logic [IW-1:0] pickIdx;
  logic [IW-1:0] candIdx;
  logic          anyReq;

  if (N < 2 || TIMEOUT < 1) begin : gParamCheck
    $error("buf_req_arbiter: N must be >= 2 and TIMEOUT >= 1");
  end

  // Search starts one past the last completed grant so every requester gets a turn.
  always_comb begin
    pickIdx = lastPtr;
    anyReq  = 1'b0;
    candIdx = '0;
    for (int k = 1; k <= N; k++) begin
      candIdx = IW'((int'(lastPtr) + k) % N);
      if (!anyReq && req[candIdx]) begin
        anyReq  = 1'b1;
        pickIdx = candIdx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] timer;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= '0;
      out_req   <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      grant_idx <= IW'(N - 1);
      lastPtr   <= IW'(N - 1);
`ifdef ARB_TIMEOUT_EN
      timer       <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (anyReq) begin
            grant_idx <= pickIdx;
            out_data  <= data_in[int'(pickIdx)*WIDTH +: WIDTH];
            out_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
`ifdef ARB_TIMEOUT_EN
            timer     <= '0;
`endif
          end
        end
        REQ: begin
          // A withdrawn req[g] here is ignored; the handshake still completes.
          if (out_ack) begin
            ack[grant_idx] <= 1'b1;
            state          <= ACKD;
          end
`ifdef ARB_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT - 1)) begin
            out_req     <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            lastPtr     <= grant_idx;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        ACKD: begin
          if (!req[grant_idx]) begin
            out_req <= 1'b0;
            state   <= DROP;
          end
        end
        DROP: begin
          if (!out_ack) begin
            ack     <= '0;
            lastPtr <= grant_idx;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buf_req_arbiter.sv
// tb/tb_buf_req_arbiter.sv - self-checking bench for buf_req_arbiter (table vectors, corner sequences, random vs model)
module tb_buf_req_arbiter;
  localparam int N       = 4;
  localparam int WIDTH   = 32;
  localparam int IW      = 2;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req = '0;
  logic [N*WIDTH-1:0] data_in = '0;
  logic [N-1:0]       ack;
  logic               out_req;
  logic [WIDTH-1:0]   out_data;
  logic               out_ack = 1'b0;
  logic               busy;
  logic [IW-1:0]      grant_idx;
  logic               err_timeout;

  int passed = 0;
  int total  = 0;
  int order[$];

  typedef struct {
    logic               doRst;
    logic [N-1:0]       mask;
    logic [N*WIDTH-1:0] slices;
    int                 bufDelay;
    int                 expG;
    logic [WIDTH-1:0]   expD;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  buf_req_arbiter #(.N(N), .WIDTH(WIDTH), .IW(IW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack), .busy(busy),
    .grant_idx(grant_idx), .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference priority list: front is highest priority; a finished grant moves to the back.
  function automatic int modelPick(input logic [N-1:0] mask);
    foreach (order[i]) if (mask[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic modelGrant(input int g);
    while (order[$] != g) order.push_back(order.pop_front());
  endtask

  task automatic doReset();
    req = '0;
    out_ack = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst.ack", ack, 0);
    chk("rst.out_req", out_req, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.grant_idx", grant_idx, N - 1);
    chk("rst.err_timeout", err_timeout, 0);
    rst = 1'b0;
    order = {0, 1, 2, 3};
  endtask

  task automatic doTransfer(input logic [N-1:0] mask, input int delay, input int expG,
                            input logic [WIDTH-1:0] expD);
    req = mask;
    tick();
    chk("grant.out_req", out_req, 1);
    chk("grant.busy", busy, 1);
    chk("grant.grant_idx", grant_idx, expG);
    chk("grant.out_data", out_data, expD);
    chk("grant.ack", ack, 0);
    repeat (delay) tick();
    if (delay > 0) chk("wait.ack", ack, 0);
    out_ack = 1'b1;
    tick();
    chk("ack.onehot", ack, N'(1) << expG);
    req[expG] = 1'b0;
    tick();
    chk("drop.out_req", out_req, 0);
    chk("drop.ack_held", ack, N'(1) << expG);
    out_ack = 1'b0;
    tick();
    chk("done.ack", ack, 0);
    chk("done.busy", busy, 0);
    chk("done.out_data", out_data, expD);
    chk("done.err_timeout", err_timeout, 0);
    modelGrant(expG);
    req = '0;
  endtask

  initial begin
    logic [N-1:0] m;
    int g;

    vecs[0] = '{1'b1, 4'b0010, {32'd0,  32'd0,  32'd5,  32'd0},  3, 1, 32'd5};
    vecs[1] = '{1'b1, 4'b1111, {32'd13, 32'd12, 32'd11, 32'd10}, 0, 0, 32'd10};
    vecs[2] = '{1'b0, 4'b1111, {32'd13, 32'd12, 32'd11, 32'd10}, 1, 1, 32'd11};
    vecs[3] = '{1'b0, 4'b1111, {32'd13, 32'd12, 32'd11, 32'd10}, 2, 2, 32'd12};
    vecs[4] = '{1'b0, 4'b1111, {32'd13, 32'd12, 32'd11, 32'd10}, 0, 3, 32'd13};
    vecs[5] = '{1'b0, 4'b1111, {32'd13, 32'd12, 32'd11, 32'd10}, 1, 0, 32'd10};
    vecs[6] = '{1'b0, 4'b1000, {32'd13, 32'd12, 32'd11, 32'd10}, 0, 3, 32'd13};
    vecs[7] = '{1'b0, 4'b1001, {32'd13, 32'd12, 32'd11, 32'd10}, 2, 0, 32'd10};
    vecs[8] = '{1'b0, 4'b1001, {32'd13, 32'd12, 32'd11, 32'd10}, 0, 3, 32'd13};
    vecs[9] = '{1'b0, 4'b0110, {32'd13, 32'd12, 32'd11, 32'd10}, 1, 1, 32'd11};

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].doRst) doReset();
      data_in = vecs[i].slices;
      doTransfer(vecs[i].mask, vecs[i].bufDelay, vecs[i].expG, vecs[i].expD);
    end

    // Data latched at grant must ignore later changes to the slice.
    doReset();
    data_in = '0;
    data_in[31:0] = 32'd7;
    req = 4'b0001;
    tick();
    chk("stab.grant", out_data, 7);
    data_in[31:0] = 32'd9;
    tick();
    chk("stab.req", out_data, 7);
    out_ack = 1'b1;
    tick();
    chk("stab.ack", ack, 4'b0001);
    req = '0;
    tick();
    chk("stab.drop", out_data, 7);
    out_ack = 1'b0;
    tick();
    chk("stab.done", out_data, 7);
    chk("stab.busy", busy, 0);

    // Requester withdraws in REQ: handshake still completes with an ack pulse.
    doReset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    chk("viol.out_req", out_req, 1);
    out_ack = 1'b1;
    tick();
    chk("viol.ack", ack, 4'b0001);
    tick();
    chk("viol.drop", out_req, 0);
    out_ack = 1'b0;
    tick();
    chk("viol.done_ack", ack, 0);
    chk("viol.done_busy", busy, 0);

    // Asynchronous reset in ACKD.
    doReset();
    data_in = {32'd4, 32'd3, 32'd2, 32'd1};
    req = 4'b0100;
    tick();
    out_ack = 1'b1;
    tick();
    chk("rstmid.ackd", ack, 4'b0100);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.ack", ack, 0);
    chk("rstmid.out_req", out_req, 0);
    chk("rstmid.busy", busy, 0);
    out_ack = 1'b0;
    req = '0;
    tick();
    rst = 1'b0;
    order = {0, 1, 2, 3};
    doTransfer(4'b0001, 1, 0, 32'd1);

    // Randomized traffic against the priority-list model.
    doReset();
    for (int i = 0; i < 40; i++) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      m = N'($urandom_range(1, 15));
      g = modelPick(m);
      doTransfer(m, $urandom_range(0, 3), g, data_in[g*WIDTH +: WIDTH]);
    end

`ifdef ARB_TIMEOUT_EN
    begin
      int cyc;
      doReset();
      data_in = {32'd4, 32'd3, 32'd2, 32'd1};
      req = 4'b0011;
      tick();
      chk("to.grant", grant_idx, 0);
      cyc = 0;
      while (out_req && cyc < 200) begin
        tick();
        cyc++;
        if (out_req) chk("to.ack_low", ack, 0);
      end
      chk("to.cycles", cyc, TIMEOUT);
      chk("to.err_pulse", err_timeout, 1);
      chk("to.ack", ack, 0);
      chk("to.busy", busy, 0);
      tick();
      chk("to.err_clear", err_timeout, 0);
      chk("to.next_grant", grant_idx, 1);
      chk("to.next_data", out_data, 2);
      out_ack = 1'b1;
      tick();
      chk("to.next_ack", ack, 4'b0010);
      req = 4'b0001;
      tick();
      out_ack = 1'b0;
      tick();
      chk("to.next_done", busy, 0);
      req = '0;
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/buf_req_arbiter.md
Name: buf_req_arbiter

Overview:
- Round-robin arbiter that shares one BUF sender-side port between N sender-style requesters, all using the four-phase REQ/ACK handshake.
- Sits between N Sender-class producers and the BUF StoB_REQ/DI/BtoS_ACK port.
- Serialises transfers: one complete four-phase handshake on the BUF side for each granted requester handshake.

Parameters:
- N, 4, number of requesters (N >= 2)
- WIDTH, 32, data bus width
- IW, $clog2(N), grant index width (derived)
- TIMEOUT, 64, cycles to wait for out_ack (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req  in  N  per-requester request, bit i = requester i
- data_in  in  N*WIDTH  requester i data on bits [i*WIDTH +: WIDTH], stable while req[i]=1
- ack  out  N  per-requester acknowledge, at most one bit set
- out_req  out  1  request to BUF (drives StoB_REQ)
- out_data  out  WIDTH  data to BUF (drives DI), registered
- out_ack  in  1  acknowledge from BUF (BtoS_ACK)
- busy  out  1  high whenever state != IDLE
- grant_idx  out  IW  index of current/last granted requester
- err_timeout  out  1  one-cycle pulse on timeout abort (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- All outputs are registered. On rst: ack=0, out_req=0, out_data=0, busy=0, grant_idx=N-1, err_timeout=0, state=IDLE, last pointer=N-1.
- Reset mid-transfer aborts immediately and drops all handshake lines. No resume.
- FSM states:
  - IDLE: if req != 0, pick the first set bit searching from last+1 mod N upward with wrap. Latch g into grant_idx and data_in slice g into out_data. Go to REQ. out_req=1 takes effect the same edge (1-cycle latency from req to out_req).
  - REQ: out_req=1. When out_ack==1, set ack[g]=1 and go to ACKD.
  - ACKD: out_req stays 1. When req[g]==0, clear out_req and go to DROP.
  - DROP: out_req=0. When out_ack==0, clear ack[g], set last=g, and go to IDLE.
- Minimum transfer: 4 cycles plus BUF and requester response times. Back-to-back grants are separated by at least one IDLE cycle.
- out_data holds its latched value until the next grant. Changes to data_in after grant are ignored.
- A req[g] withdrawn while in REQ is a protocol violation. It is ignored and the transfer completes; ack still pulses until req[g]==0 is seen in ACKD.
- Requests from non-granted requesters are held pending. Their ack stays 0.
- A request asserting in the same cycle the FSM enters IDLE is arbitrated in IDLE on the next edge.
- Fairness: with all N requesting continuously, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 transfers.
- If out_ack is already 1 on entry to REQ (stale BUF ack), the FSM waits in IDLE-to-REQ order as specified and treats it as the ack. The BUF protocol guarantees out_ack==0 by DROP exit.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter runs in REQ.
  - If out_ack stays 0 for TIMEOUT cycles: clear out_req, pulse err_timeout for 1 cycle, set last=g, and go to IDLE without asserting ack[g].
  - The requester keeps req[g] and is re-arbitrated after the others.
- Undefined: no counter; REQ waits indefinitely; err_timeout tied 0.

Test Plan:
- Single request: req=4'b0010, data_in slice1=32'h0000_0005, BUF acks after 3 cycles -> out_req rises 1 cycle after req; out_data=5; grant_idx=1; ack[1] rises the cycle after out_ack; full four-phase completes; busy returns 0.
- Contention: req=4'b1111 held continuously, slices 10,11,12,13 -> out_data sequence 10,11,12,13,10 and grant_idx 0,1,2,3,0.
- Wrap priority: after granting requester 3, req=4'b1001 -> requester 0 granted next; then requester 3.
- Data stability: change slice g from 7 to 9 during REQ -> out_data stays 7 through the transfer.
- Reset mid-transfer: assert rst in ACKD -> ack, out_req, busy go to 0 asynchronously; after release, req=4'b0001 is granted to index 0.
- ARB_TIMEOUT_EN, TIMEOUT=64, out_ack held 0 -> out_req drops at cycle 64 of REQ; err_timeout=1 for exactly 1 cycle; ack stays 0; with req=4'b0011 and g=0, requester 1 is granted next.
